// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Each accepted operation takes three cycles: IDLE (handshake), EXEC, RESP.
// Operands are latched at the handshake and drive the ALU until the next one.
// The result is captured at the end of EXEC and is pulsed for one cycle to
// the requester that issued the operation.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on conflict;
// without it, requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_y,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               grant_s;
    logic               hs_s;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [2:0]         op_f_r;
    logic               op_id_r;
    logic               rsp0_valid_r;
    logic               rsp1_valid_r;
    logic [WIDTH-1:0]   rsp0_y_r;
    logic [WIDTH-1:0]   rsp1_y_r;
    logic               rsp0_zero_r;
    logic               rsp1_zero_r;
`ifdef ALU_ARB_RR_EN
    logic               last_r;
`endif

    // Arbitration: pick requester 1 only when it alone is valid or wins a conflict.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
            grant_s = ~last_r;
`else
            grant_s = 1'b0;
`endif
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // State register; reset always returns to IDLE, aborting any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: a handshake leaves IDLE, then EXEC and RESP last one cycle each.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = hs_s ? EXEC : IDLE;
            EXEC:    state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Outputs of the FSM: ready only in IDLE for the granted valid requester, busy otherwise.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b1;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (!reset) begin
                    req0_ready = req0_valid && !grant_s;
                    req1_ready = req1_valid && grant_s;
                end else begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b0;
                end
            end
            EXEC:    busy = 1'b1;
            RESP:    busy = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    assign hs_s = req0_ready | req1_ready;

    // Datapath: latch operands on handshake, capture the ALU result at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_r       <= {WIDTH{1'b0}};
            op_b_r       <= {WIDTH{1'b0}};
            op_f_r       <= 3'b000;
            op_id_r      <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_y_r     <= {WIDTH{1'b0}};
            rsp1_y_r     <= {WIDTH{1'b0}};
            rsp0_zero_r  <= 1'b0;
            rsp1_zero_r  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_r       <= 1'b1;
`endif
        end else begin
            if (hs_s) begin
                op_a_r  <= req1_ready ? req1_a : req0_a;
                op_b_r  <= req1_ready ? req1_b : req0_b;
                op_f_r  <= req1_ready ? req1_f : req0_f;
                op_id_r <= req1_ready;
`ifdef ALU_ARB_RR_EN
                last_r  <= req1_ready;
`endif
            end
            rsp0_valid_r <= (state_r == EXEC) && (op_id_r == 1'b0);
            rsp1_valid_r <= (state_r == EXEC) && (op_id_r == 1'b1);
            if ((state_r == EXEC) && (op_id_r == 1'b0)) begin
                rsp0_y_r    <= alu_y;
                rsp0_zero_r <= alu_zero;
            end
            if ((state_r == EXEC) && (op_id_r == 1'b1)) begin
                rsp1_y_r    <= alu_y;
                rsp1_zero_r <= alu_zero;
            end
        end
    end

    assign alu_a      = op_a_r;
    assign alu_b      = op_b_r;
    assign alu_f      = op_f_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_y     = rsp0_y_r;
    assign rsp1_y     = rsp1_y_r;
    assign rsp0_zero  = rsp0_zero_r;
    assign rsp1_zero  = rsp1_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (grant rule, 2-cycle response, held results).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
    logic [31:0] rsp0_y, rsp1_y;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        alu_zero;
    logic        busy;
    int          tests = 0;
    int          fails = 0;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    // Bench ALU: AND, OR, everything else returns 0.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_y    = alu_ref(alu_a, alu_b, alu_f);
    assign alu_zero = (alu_y == 32'h0);

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero),
        .busy(busy)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        tests++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
        tests++; if (rsp0_y !== 32'h0 || rsp1_y !== 32'h0) begin fails++; $display("FAIL reset_rsp_y: got %h %h want 0 0", rsp0_y, rsp1_y); end
        tests++; if ({rsp0_zero, rsp1_zero} !== 2'b00) begin fails++; $display("FAIL reset_rsp_zero: got %b want 00", {rsp0_zero, rsp1_zero}); end
        tests++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_f !== 3'b000) begin fails++; $display("FAIL reset_alu_in: got %h %h %b want 0", alu_a, alu_b, alu_f); end
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // One operation from requester id; handshake on edge T, response seen after edge T+1.
    task automatic test_single(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                               input logic [31:0] exp_y, input logic exp_z, input string name);
        logic        rdy, ordy, rv, orv, rz;
        logic [31:0] ry;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f; end
        #1;
        rdy = id ? req1_ready : req0_ready; ordy = id ? req0_ready : req1_ready;
        tests++; if (rdy !== 1'b1 || ordy !== 1'b0) begin fails++; $display("FAIL %s_ready: got %b/%b want 1/0", name, rdy, ordy); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_exec: got %b want 1", name, busy); end
        tests++; if (alu_a !== a || alu_b !== b || alu_f !== f) begin fails++; $display("FAIL %s_alu_drive: got %h %h %b want %h %h %b", name, alu_a, alu_b, alu_f, a, b, f); end
        tests++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin fails++; $display("FAIL %s_early_rsp: got %b want 00", name, {rsp0_valid, rsp1_valid}); end
        @(negedge clk);
        rv = id ? rsp1_valid : rsp0_valid; orv = id ? rsp0_valid : rsp1_valid;
        ry = id ? rsp1_y : rsp0_y; rz = id ? rsp1_zero : rsp0_zero;
        tests++; if (rv !== 1'b1 || orv !== 1'b0) begin fails++; $display("FAIL %s_rsp_valid: got %b/%b want 1/0", name, rv, orv); end
        tests++; if (ry !== exp_y || rz !== exp_z) begin fails++; $display("FAIL %s_result: got %h/%b want %h/%b", name, ry, rz, exp_y, exp_z); end
        @(negedge clk);
        rv = id ? rsp1_valid : rsp0_valid; ry = id ? rsp1_y : rsp0_y;
        tests++; if (rv !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL %s_after: got valid %b busy %b want 0 0", name, rv, busy); end
        tests++; if (ry !== exp_y) begin fails++; $display("FAIL %s_hold: got %h want %h", name, ry, exp_y); end
    endtask

    task automatic test_conflict();
        int grants[4];
        int n = 0;
        int n1 = 0;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'hAAAA0000; req0_b = 32'hFFFFFFFF; req0_f = 3'b000;
        req1_a = 32'h00005555; req1_b = 32'h00000000; req1_f = 3'b001;
        for (int c = 0; c < 30 && n < 4; c++) begin
            #1;
            tests++; if (req0_ready && req1_ready) begin fails++; $display("FAIL conflict_both_ready: got 11 want at most one"); end
            if (req0_ready || req1_ready) begin
                grants[n] = req1_ready ? 1 : 0;
                if (req1_ready) n1++;
                n++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests++; if (n !== 4) begin fails++; $display("FAIL conflict_timeout: got %0d grants want 4", n); end
        for (int i = 0; i < n; i++) begin
            tests++; if (grants[i] !== (RR ? (i % 2) : 0)) begin fails++; $display("FAIL conflict_grant%0d: got %0d want %0d", i, grants[i], RR ? (i % 2) : 0); end
        end
        tests++; if (n1 !== (RR ? 2 : 0)) begin fails++; $display("FAIL conflict_req1_grants: got %0d want %0d", n1, RR ? 2 : 0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h000000FF; req0_b = 32'h000000FF; req0_f = 3'b000;
        @(negedge clk);
        req0_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rexec_busy: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rexec_busy_after: got %b want 0", busy); end
        tests++; if (rsp0_y !== 32'h0 || rsp1_y !== 32'h0) begin fails++; $display("FAIL rexec_rsp_y: got %h %h want 0 0", rsp0_y, rsp1_y); end
        req1_valid = 1'b1;
        #1;
        tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL rexec_first_idle_ready: got %b want 1", req1_ready); end
        #1 req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin fails++; $display("FAIL rexec_no_rsp%0d: got %b want 00", i, {rsp0_valid, rsp1_valid}); end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        logic [31:0] exp_y = 32'h12345678 & 32'h0F0F0F0F;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h12345678; req0_b = 32'h0F0F0F0F; req0_f = 3'b000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req0_a = $urandom; req0_b = $urandom; req0_f = 3'($urandom_range(0, 7));
            #1;
            tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL hold_ready%0d: got %b want 0", i, req0_ready); end
        end
        tests++; if (rsp0_valid !== 1'b1 || rsp0_y !== exp_y) begin fails++; $display("FAIL hold_result: got %b/%h want 1/%h", rsp0_valid, rsp0_y, exp_y); end
        @(negedge clk);
        #1;
        tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL hold_ready_idle: got %b want 1", req0_ready); end
        #1 req0_valid = 1'b0;
        @(negedge clk);
    endtask

    // Randomized traffic against a transaction-level model of the arbiter.
    task automatic test_random();
        int          remaining = 0;
        bit          last = 1'b1;
        bit          pend = 1'b0;
        bit          pend_id = 1'b0;
        int          pend_at = 0;
        logic [31:0] pend_y = 32'h0;
        logic [31:0] hold_y[2];
        logic        hold_z[2];
        logic        pend_z = 1'b0;
        bit          idle, g, er0, er1, ev0, ev1;
        do_reset();
        hold_y[0] = 32'h0; hold_y[1] = 32'h0; hold_z[0] = 1'b0; hold_z[1] = 1'b0;
        for (int k = 0; k < 300; k++) begin
            req0_valid = ($urandom_range(0, 2) != 0); req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = $urandom; req0_b = $urandom; req0_f = 3'($urandom_range(0, 3));
            req1_a = $urandom; req1_b = $urandom; req1_f = 3'($urandom_range(0, 3));
            #1;
            idle = (remaining == 0);
            if (req0_valid && req1_valid) g = RR ? !last : 1'b0;
            else g = req1_valid;
            er0 = idle && req0_valid && !g;
            er1 = idle && req1_valid && g;
            ev0 = pend && pend_at == k && !pend_id;
            ev1 = pend && pend_at == k && pend_id;
            if (pend && pend_at == k) begin
                hold_y[pend_id] = pend_y; hold_z[pend_id] = pend_z; pend = 1'b0;
            end
            tests++; if ({req0_ready, req1_ready} !== {er0, er1}) begin fails++; $display("FAIL rand_ready@%0d: got %b want %b", k, {req0_ready, req1_ready}, {er0, er1}); end
            tests++; if ({rsp0_valid, rsp1_valid} !== {ev0, ev1}) begin fails++; $display("FAIL rand_rsp_valid@%0d: got %b want %b", k, {rsp0_valid, rsp1_valid}, {ev0, ev1}); end
            tests++; if (rsp0_y !== hold_y[0] || rsp0_zero !== hold_z[0]) begin fails++; $display("FAIL rand_rsp0@%0d: got %h/%b want %h/%b", k, rsp0_y, rsp0_zero, hold_y[0], hold_z[0]); end
            tests++; if (rsp1_y !== hold_y[1] || rsp1_zero !== hold_z[1]) begin fails++; $display("FAIL rand_rsp1@%0d: got %h/%b want %h/%b", k, rsp1_y, rsp1_zero, hold_y[1], hold_z[1]); end
            tests++; if (busy !== !idle) begin fails++; $display("FAIL rand_busy@%0d: got %b want %b", k, busy, !idle); end
            if (er0 || er1) begin
                pend = 1'b1; pend_id = g; pend_at = k + 2; last = g; remaining = 2;
                pend_y = g ? alu_ref(req1_a, req1_b, req1_f) : alu_ref(req0_a, req0_b, req0_f);
                pend_z = (pend_y == 32'h0);
            end else if (remaining > 0) begin
                remaining--;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'h0; req0_b = 32'h0; req0_f = 3'b000;
        req1_a = 32'h0; req1_b = 32'h0; req1_f = 3'b000;
        repeat (2) @(negedge clk);
        test_reset();
        test_single(1'b0, 32'h000000F0, 32'h0000000F, 3'b000, 32'h00000000, 1'b1, "and_req0");
        test_single(1'b1, 32'h0000F000, 32'h000000FF, 3'b001, 32'h0000F0FF, 1'b0, "or_req1");
        test_single(1'b0, 32'h00000001, 32'h00000001, 3'b011, 32'h00000000, 1'b1, "unused_f");
        test_conflict();
        test_reset_exec();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width (only 32 is supported).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  operation from requester N accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-007 SHALL have ports req0_f / req1_f  input  3 each  ALU function code.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid  output  1 each  one-cycle result pulse to requester N.
REQ-009 SHALL have ports rsp0_y / rsp1_y  output  WIDTH each; rsp0_zero / rsp1_zero  output  1 each  result and zero flag.
REQ-010 SHALL have ports alu_a, alu_b  output  WIDTH each; alu_f  output  3  drive the shared combinational ALU.
REQ-011 SHALL have ports alu_y  input  WIDTH; alu_zero  input  1  shared ALU result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, EXEC, RESP; transitions IDLE->EXEC on handshake, EXEC->RESP always, RESP->IDLE always.
REQ-014 SHALL assert reqN_ready combinationally only in IDLE, only for the granted requester, only when that requester's valid is high; at most one ready high per cycle.
REQ-015 SHALL treat a handshake as reqN_valid && reqN_ready on a rising edge; operands and f are latched into internal registers with the requester ID on that edge.
REQ-016 SHALL drive alu_a, alu_b, alu_f from the latched registers in every state; values hold until the next handshake.
REQ-017 SHALL capture alu_y and alu_zero into result registers at the end of EXEC.
REQ-018 SHALL in RESP pulse rspN_valid for exactly one cycle to the latched requester ID only; the other rsp_valid stays 0.
REQ-019 SHALL hold rspN_y/rspN_zero at their last captured value when rspN_valid is low.
REQ-020 SHALL have fixed latency: handshake on edge T -> rsp_valid high during cycle T+2; peak throughput one operation per 3 cycles.
REQ-021 SHALL forward all f codes, including unused ones, unchanged; result is whatever the ALU returns.
REQ-022 SHALL ignore reqN_valid and operand changes outside IDLE; a requester may drop valid before ready with no transaction created.
REQ-023 SHALL with both valid in IDLE grant per REQ-030/031; with one valid grant it regardless of pointer.
REQ-024 SHALL update the last-grant pointer only on a handshake.

Reset
REQ-025 SHALL on reset force state IDLE, busy 0, both ready 0 in the reset cycle, both rsp_valid 0.
REQ-026 SHALL on reset clear latched operands, f, result registers, rsp_y and rsp_zero to 0, and set the last-grant pointer to 1.
REQ-027 SHALL on reset during EXEC or RESP abort the operation; no rsp_valid pulse for it ever occurs.
REQ-028 SHALL accept a new request in the first IDLE cycle after reset deasserts.
REQ-029 SHALL treat reset as overriding every other input on the same edge.

Configuration
REQ-030 SHALL with ALU_ARB_RR_EN defined use round-robin: on conflict grant the requester not indicated by the last-grant pointer.
REQ-031 SHALL without ALU_ARB_RR_EN use fixed priority: on conflict requester 0 always wins; pointer unused.

Verification (bench ALU model: f=000 AND, f=001 OR, zero = (y==0))
REQ-032 SHALL cover: req0 a=0x000000F0 b=0x0000000F f=000, handshake at T -> rsp0_valid at T+2, rsp0_y=0, rsp0_zero=1, rsp1_valid=0.
REQ-033 SHALL cover: req1 a=0x0000F000 b=0x000000FF f=001 -> rsp1_valid at T+2, rsp1_y=0x0000F0FF, rsp1_zero=0.
REQ-034 SHALL cover: both valid continuously, RR build, 4 ops -> grants 0,1,0,1; non-RR build -> grants 0,0,0,0 and req1_ready never high.
REQ-035 SHALL cover: reset asserted one cycle during EXEC -> no rsp_valid for that op, busy=0 next cycle, all rsp_y=0.
REQ-036 SHALL cover: req0 valid held through EXEC/RESP with changing operands -> req0_ready=0 until IDLE, result reflects operands latched at handshake.
REQ-037 SHALL cover: f=011 (unused) a=1 b=1 -> alu_f=011 during EXEC, rsp0_y equals bench ALU output (0), rsp0_zero=1.
